rr_mux_pipe: RTL
================

// Module: rr_mux_pipe
// PURPOSE
//  Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every port.
//  Generalises the fixed 2:1 datapath muxes: any width, any input count, plus a round-robin arbitration mode.
//  Sits between producers (e.g. forwarding, writeback or memory-return paths) and a single consumer stage.
//  Output is registered: one pipeline stage, full throughput.
// PARAMETERS
//  WIDTH   32  data width per channel, in bits (>=1)
//  NUM_IN  4   number of input channels (>=2)
//  SEL_W   2   select width; must be >= clog2(NUM_IN)
//  MODE    0   0 = explicit select via sel; 1 = round-robin arbitration (sel is ignored)
// PORTS
//  Clk       in   1             clock; all state updates on the rising edge
//  Reset     in   1             synchronous, active-low reset
//  in_data   in   NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid  in   NUM_IN        per-channel data-valid
//  in_ready  out  NUM_IN        per-channel accept; combinational
//  sel       in   SEL_W         channel select, used in MODE 0 only
//  out_data  out  WIDTH         registered output word
//  out_valid out  1             out_data holds a valid word
//  out_ready in   1             consumer accepts out_data this cycle
//  out_src   out  SEL_W         index of the channel that supplied out_data
// BEHAVIOUR
//  Reset (Reset==0 at a rising edge):
//   - out_data=0, out_valid=0, out_src=0, rr_ptr=0.
//   - in_ready is all 0 while Reset==0 (combinational gate).
//   - A word held in the output register is discarded; no input is accepted in that cycle.
//  Register free: load_en = !out_valid | out_ready.
//  Grant g, combinational:
//   - MODE 0: g=sel if sel<NUM_IN and in_valid[sel]; otherwise no grant.
//   - MODE 1: g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN.
//     No grant if in_valid==0.
//  Ready generation:
//   - in_ready[i] = Reset & load_en & (i==g) & grant_exists.
//   - At most one in_ready bit is high in any cycle.
//  Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
//   - out_data <= in_data[i], out_src <= i, out_valid <= 1.
//   - MODE 1 only: rr_ptr <= (i==NUM_IN-1) ? 0 : i+1.
//  No transfer, but out_ready=1: out_valid <= 0; out_data and out_src hold their values.
//  Backpressure (out_valid & !out_ready): out_data, out_src, out_valid and rr_ptr are frozen; all in_ready=0.
//  Latency: a word accepted at edge k appears on out_data after edge k.
//  Throughput: one word per cycle when out_ready is held at 1 (accept and drain on the same edge).
//  Fairness (MODE 1): a continuously valid channel is granted within NUM_IN transfers.
//  rr_ptr does not advance on cycles with no transfer.
//  MODE 0, sel changed while stalled: has no effect until load_en; the new sel applies on the next free cycle.
//  MODE 0, sel >= NUM_IN (non-power-of-two NUM_IN): no grant, out_valid drains, nothing is accepted.
//  Producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.
// TESTING
//  T1 reset: hold Reset=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 every cycle.
//  T2 MODE0 stream: NUM_IN=4, sel=2, in_data[2]=0xA5A5A5A5, in_valid=4'b0100, out_ready=1
//     -> in_ready=4'b0100; next cycle out_data=0xA5A5A5A5, out_src=2, out_valid=1.
//  T3 backpressure: after T2, set out_ready=0 for 3 cycles while in_data[2] changes
//     -> out_data stays 0xA5A5A5A5, in_ready=0; on release, the new word appears one cycle later.
//  T4 MODE1 fairness: in_valid=4'b1111, out_ready=1 for 8 cycles
//     -> out_src sequence 0,1,2,3,0,1,2,3 with no bubbles.
//  T5 MODE1 skip and wrap: rr_ptr=3, in_valid=4'b0010 -> grant 1, rr_ptr becomes 2.
//     Then in_valid=4'b0001 -> grant 0, rr_ptr becomes 1.
//  T6 reset mid-stall: out_valid=1 with out_ready=0, pulse Reset=0 for one edge
//     -> out_valid=0, rr_ptr=0, the held word is lost, and normal operation resumes the next cycle.

Source files
------------

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe
//   N-input, W-bit registered multiplexer with a valid/ready handshake on
//   every port. One output register stage, full throughput: a word can be
//   accepted on the same edge that the previous word is drained.
//   MODE 0 picks the input named by sel; MODE 1 arbitrates round-robin
//   starting from the channel after the last one granted.
//
// Ports
//   Clk        clock, all state changes on the rising edge
//   Reset      synchronous, active-low reset
//   in_data    NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (combinational, at most one bit set)
//   sel        channel select, only used when MODE == 0
//   out_data   registered output word
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_src    index of the channel that supplied out_data
module rr_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic                 loadEn;
  logic                 grantValid;
  logic [SEL_W-1:0]     grantIdx;
  logic [SEL_W-1:0]     rrPtr;
  logic [2*NUM_IN-1:0]  rotValid;
  logic [WIDTH-1:0]     selData;
  logic                 xfer;
  int                   rotSum;

  // The output register can take a new word when it is empty or being drained.
  assign loadEn = !out_valid || out_ready;

  // Grant selection. In round-robin mode the valid vector is rotated so that
  // bit 0 corresponds to rrPtr; scanning downwards leaves the lowest set bit,
  // i.e. the first valid channel at or after the pointer, as the winner.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    rotValid   = '0;
    rotSum     = 0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grantValid = 1'b1;
          grantIdx   = SEL_W'(i);
        end
      end
    end else begin
      rotValid = {in_valid, in_valid} >> rrPtr;
      for (int j = NUM_IN - 1; j >= 0; j--) begin
        if (rotValid[j]) begin
          grantValid = 1'b1;
          rotSum     = int'(rrPtr) + j;
          if (rotSum >= NUM_IN) begin
            rotSum = rotSum - NUM_IN;
          end
          grantIdx = SEL_W'(rotSum);
        end
      end
    end
  end

  // One-hot ready toward the granted channel, and the matching data word.
  // Reset gates ready so nothing is accepted while the block is held in reset.
  always_comb begin
    in_ready = '0;
    selData  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = Reset && loadEn && grantValid && (grantIdx == SEL_W'(i));
      if (grantIdx == SEL_W'(i)) begin
        selData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and round-robin pointer. Without a transfer the word
  // is dropped only if the consumer took it; under backpressure everything
  // holds. The pointer only moves on a transfer.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      rrPtr     <= '0;
    end else if (xfer) begin
      out_data  <= selData;
      out_valid <= 1'b1;
      out_src   <= grantIdx;
      if (MODE == 1) begin
        if (grantIdx == SEL_W'(NUM_IN - 1)) begin
          rrPtr <= '0;
        end else begin
          rrPtr <= grantIdx + SEL_W'(1);
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
